// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle mult/div sequencer owning HI/LO, with D-stage stall
//   in : clk, reset (sync, active-high), start, mdOp[2:0], A[31:0], B[31:0], mdUseD
//   out: busy, stallMD, hi[31:0], lo[31:0]
//   optional macro MD_DIVZERO_HOLD_EN: divide by zero leaves hi/lo unchanged after one busy cycle
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        mdUseD,
  output logic        busy,
  output logic        stallMD,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [31:0] cnt, pend_hi, pend_lo, res_hi, res_lo, sdv, udv, sq, sr, uq, ur, load;
  logic [63:0] prod_s, prod_u;
  logic wb, is_md, is_div, dz, ovf, idle_req, accept, hold;
  assign is_md    = (mdOp != 3'd0) && (mdOp <= 3'd4);
  assign is_div   = (mdOp == 3'd3) || (mdOp == 3'd4);
  assign idle_req = (state == IDLE) && start;
  assign accept   = idle_req && is_md;
  assign busy     = (state == BUSY);
  assign stallMD  = mdUseD & (busy | (start & is_md));
  assign dz       = is_div && (B == 32'd0);
  assign ovf      = (mdOp == 3'd3) && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
`ifdef MD_DIVZERO_HOLD_EN
  assign hold = dz;
`else
  assign hold = 1'b0;
`endif
  // Divisors are forced to 1 in the special cases so the dividers never see 0 or overflow
  assign sdv    = (dz || ovf) ? 32'd1 : B;
  assign udv    = dz ? 32'd1 : B;
  assign sq     = $signed(A) / $signed(sdv);
  assign sr     = $signed(A) % $signed(sdv);
  assign uq     = A / udv;
  assign ur     = A % udv;
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign load   = hold ? 32'd0 : is_div ? 32'(DIV_CYCLES - 1) : 32'(MULT_CYCLES - 1);
  always_comb begin
    res_hi  = (mdOp == 3'd1) ? prod_s[63:32] : (mdOp == 3'd2) ? prod_u[63:32] :
              dz ? A : (mdOp == 3'd3) ? (ovf ? 32'd0 : sr) : ur;
    res_lo  = (mdOp == 3'd1) ? prod_s[31:0] : (mdOp == 3'd2) ? prod_u[31:0] :
              dz ? 32'hFFFF_FFFF : (mdOp == 3'd3) ? (ovf ? 32'h8000_0000 : sq) : uq;
    state_n = (state == IDLE) ? (accept ? BUSY : IDLE) : ((cnt == 32'd0) ? IDLE : BUSY);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      wb      <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      state <= state_n;
      if (accept) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        cnt     <= load;
        wb      <= !hold;
      end else if (busy && cnt != 32'd0) begin
        cnt <= cnt - 32'd1;
      end
      if (busy && cnt == 32'd0 && wb) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
      if (idle_req && mdOp == 3'd5) hi <= A;
      if (idle_req && mdOp == 3'd6) lo <= A;
    end
  end
endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: table-driven check of md_unit_ctrl plus stall/reset corner sequences
module tb_md_unit_ctrl;
  logic clk = 0, reset = 1, start = 0, mdUseD = 0;
  logic [2:0] mdOp = 0;
  logic [31:0] A = 0, B = 0;
  logic busy, stallMD;
  logic [31:0] hi, lo;
  int tests = 0, fails = 0;

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdOp(mdOp), .A(A), .B(B),
    .mdUseD(mdUseD), .busy(busy), .stallMD(stallMD), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          cyc;
  } vec_t;
  vec_t v[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     output int n, output logic bad);
    logic md;
    md = (op >= 3'd1) && (op <= 3'd4);
    bad = 0;
    n = 0;
    @(negedge clk);
    start = 1; mdOp = op; A = a; B = b;
    #1;
    if (stallMD !== (mdUseD & md)) bad = 1;
    @(negedge clk);
    start = 0; mdOp = 0;
    #1;
    while (busy === 1'b1 && n < 100) begin
      if (stallMD !== mdUseD) bad = 1;
      n++;
      @(negedge clk);
      #1;
    end
    if (stallMD !== 1'b0) bad = 1;
  endtask

  initial begin
    int n;
    logic bad;
    v[0]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    v[1]  = '{3'd4, 32'd100,       32'd7,          32'd2,         32'd14,        10};
    v[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    v[3]  = '{3'd5, 32'h1234,      32'd0,          32'h1234,      32'hFFFF_FFFD, 0};
    v[4]  = '{3'd6, 32'h5678,      32'd0,          32'h1234,      32'h5678,      0};
    v[5]  = '{3'd0, 32'hDEAD,      32'd1,          32'h1234,      32'h5678,      0};
    v[6]  = '{3'd7, 32'hBEEF,      32'd1,          32'h1234,      32'h5678,      0};
    v[7]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    v[8]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 10};
`ifdef MD_DIVZERO_HOLD_EN
    v[9]  = '{3'd3, 32'd5,         32'd0,          32'h0,         32'h8000_0000, 1};
    v[10] = '{3'd4, 32'd7,         32'd0,          32'h0,         32'h8000_0000, 1};
`else
    v[9]  = '{3'd3, 32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF, 10};
    v[10] = '{3'd4, 32'd7,         32'd0,          32'd7,         32'hFFFF_FFFF, 10};
`endif
    v[11] = '{3'd1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
    v[12] = '{3'd3, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2,         10};
    v[13] = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         5};

    repeat (2) @(negedge clk);
    mdUseD = 1;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_stall", {31'd0, stallMD}, 32'd0);
    reset = 0;

    for (int i = 0; i < 14; i++) begin
      run(v[i].op, v[i].a, v[i].b, n, bad);
      chk($sformatf("vec%0d_cycles", i), n, v[i].cyc);
      chk($sformatf("vec%0d_hi", i), hi, v[i].hi);
      chk($sformatf("vec%0d_lo", i), lo, v[i].lo);
      chk($sformatf("vec%0d_stall", i), {31'd0, bad}, 32'd0);
    end

    // mult in flight; div then mtlo requested while busy must be ignored
    mdUseD = 0;
    @(negedge clk);
    start = 1; mdOp = 3'd1; A = 32'd6; B = 32'd7;
    @(negedge clk);
    start = 0; mdOp = 0; n = 0; bad = 0;
    #1;
    while (busy === 1'b1 && n < 100) begin
      if (n == 1) begin start = 1; mdOp = 3'd3; A = 32'd100; B = 32'd7; end
      if (n == 3) begin mdOp = 3'd6; A = 32'hFFFF; end
      if (n == 4) start = 0;
      #1;
      if (stallMD !== 1'b0) bad = 1;
      n++;
      @(negedge clk);
      #1;
    end
    start = 0; mdOp = 0;
    chk("busy_ignore_cycles", n, 5);
    chk("busy_ignore_hi", hi, 32'd0);
    chk("busy_ignore_lo", lo, 32'h2A);
    chk("nouse_stall", {31'd0, bad}, 32'd0);
    repeat (3) @(negedge clk);
    chk("busy_ignore_idle", {31'd0, busy}, 32'd0);

    // reset in the third busy cycle of a mult drops the result
    mdUseD = 1;
    @(negedge clk);
    start = 1; mdOp = 3'd1; A = 32'hFFFF_FFFE; B = 32'd3;
    @(negedge clk);
    start = 0; mdOp = 0; n = 0;
    while (busy === 1'b1 && n < 2) begin
      n++;
      @(negedge clk);
    end
    chk("rst_mid_busy", {31'd0, busy}, 32'd1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    repeat (8) @(negedge clk);
    chk("rst_late_busy", {31'd0, busy}, 32'd0);
    chk("rst_late_hi", hi, 32'd0);
    chk("rst_late_lo", lo, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
